// File: rtl/alu_arbiter.sv
// Shares one combinational 32-bit ALU between two valid/ready requesters (round-robin or fixed priority).
// Latency: op accepted at edge k drives the ALU in cycle k+1; result buffered and visible after edge k+1.
// Backpressure: one op outstanding per requester; its ready stays low while its op or unread result is held.
module alu_arbiter #(
    parameter int DATA_W     = 32,
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic              clk_i,
    input  logic              reset_i,

    input  logic              r0_valid_i,
    output logic              r0_ready_o,
    input  logic [DATA_W-1:0] r0_src1_i,
    input  logic [DATA_W-1:0] r0_src2_i,
    input  logic [3:0]        r0_func1_i,
    input  logic [1:0]        r0_func2_i,
    output logic              r0_rvalid_o,
    output logic [DATA_W-1:0] r0_result_o,
    input  logic              r0_rready_i,

    input  logic              r1_valid_i,
    output logic              r1_ready_o,
    input  logic [DATA_W-1:0] r1_src1_i,
    input  logic [DATA_W-1:0] r1_src2_i,
    input  logic [3:0]        r1_func1_i,
    input  logic [1:0]        r1_func2_i,
    output logic              r1_rvalid_o,
    output logic [DATA_W-1:0] r1_result_o,
    input  logic              r1_rready_i,

    output logic [DATA_W-1:0] alu_src1_o,
    output logic [DATA_W-1:0] alu_src2_o,
    output logic [3:0]        alu_func1_o,
    output logic [1:0]        alu_func2_o,
    input  logic [DATA_W-1:0] alu_out_i
);

    localparam logic [3:0] FUNC1_IDLE = 4'b1111;

    logic              stage_v_q, stage_v_d;
    logic              stage_id_q, stage_id_d;
    logic [DATA_W-1:0] stage_src1_q, stage_src1_d;
    logic [DATA_W-1:0] stage_src2_q, stage_src2_d;
    logic [3:0]        stage_func1_q, stage_func1_d;
    logic [1:0]        stage_func2_q, stage_func2_d;
    logic [1:0]        rbuf_v_q, rbuf_v_d;
    logic [DATA_W-1:0] rbuf0_dat_q, rbuf0_dat_d;
    logic [DATA_W-1:0] rbuf1_dat_q, rbuf1_dat_d;
    logic              last_grant_q, last_grant_d;

    logic busy0, busy1, elig0, elig1, grant0, grant1;

    // A requester is busy while its op sits in the stage or its result waits unread.
    always_comb begin
        busy0  = (stage_v_q && !stage_id_q) || (rbuf_v_q[0] && !r0_rready_i);
        busy1  = (stage_v_q && stage_id_q)  || (rbuf_v_q[1] && !r1_rready_i);
        elig0  = r0_valid_i && !busy0;
        elig1  = r1_valid_i && !busy1;
        grant0 = elig0;
        grant1 = elig1;
        if (elig0 && elig1) begin
            if (PRIO_FIXED || last_grant_q) begin
                grant0 = 1'b1;
                grant1 = 1'b0;
            end else begin
                grant0 = 1'b0;
                grant1 = 1'b1;
            end
        end
    end

    always_comb begin
        stage_v_d     = grant0 || grant1;
        stage_id_d    = stage_id_q;
        stage_src1_d  = '0;
        stage_src2_d  = '0;
        stage_func1_d = FUNC1_IDLE;
        stage_func2_d = 2'b00;
        last_grant_d  = last_grant_q;
        if (grant0) begin
            stage_id_d    = 1'b0;
            stage_src1_d  = r0_src1_i;
            stage_src2_d  = r0_src2_i;
            stage_func1_d = r0_func1_i;
            stage_func2_d = r0_func2_i;
            last_grant_d  = 1'b0;
        end else if (grant1) begin
            stage_id_d    = 1'b1;
            stage_src1_d  = r1_src1_i;
            stage_src2_d  = r1_src2_i;
            stage_func1_d = r1_func1_i;
            stage_func2_d = r1_func2_i;
            last_grant_d  = 1'b1;
        end
    end

    // Load and drain never coincide for one buffer, so load simply takes precedence.
    always_comb begin
        rbuf_v_d    = rbuf_v_q;
        rbuf0_dat_d = rbuf0_dat_q;
        rbuf1_dat_d = rbuf1_dat_q;
        if (rbuf_v_q[0] && r0_rready_i) rbuf_v_d[0] = 1'b0;
        if (rbuf_v_q[1] && r1_rready_i) rbuf_v_d[1] = 1'b0;
        if (stage_v_q && !stage_id_q) begin
            rbuf_v_d[0] = 1'b1;
            rbuf0_dat_d = alu_out_i;
        end
        if (stage_v_q && stage_id_q) begin
            rbuf_v_d[1] = 1'b1;
            rbuf1_dat_d = alu_out_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stage_v_q     <= 1'b0;
            stage_id_q    <= 1'b0;
            stage_src1_q  <= '0;
            stage_src2_q  <= '0;
            stage_func1_q <= FUNC1_IDLE;
            stage_func2_q <= 2'b00;
            rbuf_v_q      <= 2'b00;
            rbuf0_dat_q   <= '0;
            rbuf1_dat_q   <= '0;
            last_grant_q  <= 1'b1;
        end else begin
            stage_v_q     <= stage_v_d;
            stage_id_q    <= stage_id_d;
            stage_src1_q  <= stage_src1_d;
            stage_src2_q  <= stage_src2_d;
            stage_func1_q <= stage_func1_d;
            stage_func2_q <= stage_func2_d;
            rbuf_v_q      <= rbuf_v_d;
            rbuf0_dat_q   <= rbuf0_dat_d;
            rbuf1_dat_q   <= rbuf1_dat_d;
            last_grant_q  <= last_grant_d;
        end
    end

    assign r0_ready_o  = grant0;
    assign r1_ready_o  = grant1;
    assign r0_rvalid_o = rbuf_v_q[0];
    assign r1_rvalid_o = rbuf_v_q[1];
    assign r0_result_o = rbuf0_dat_q;
    assign r1_result_o = rbuf1_dat_q;
    assign alu_src1_o  = stage_src1_q;
    assign alu_src2_o  = stage_src2_q;
    assign alu_func1_o = stage_func1_q;
    assign alu_func2_o = stage_func2_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: round-robin instance plus a fixed-priority instance on shared inputs.
module tb_alu_arbiter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        r0_valid_i, r1_valid_i, r0_rready_i, r1_rready_i;
    logic [31:0] r0_src1_i, r0_src2_i, r1_src1_i, r1_src2_i;
    logic [3:0]  r0_func1_i, r1_func1_i;
    logic [1:0]  r0_func2_i, r1_func2_i;

    logic        r0_ready_o, r1_ready_o, r0_rvalid_o, r1_rvalid_o;
    logic [31:0] r0_result_o, r1_result_o, alu_src1_o, alu_src2_o, alu_out_i;
    logic [3:0]  alu_func1_o;
    logic [1:0]  alu_func2_o;

    logic        f_r0_ready, f_r1_ready, f_r0_rvalid, f_r1_rvalid;
    logic [31:0] f_r0_result, f_r1_result, f_alu_src1, f_alu_src2, f_alu_out;
    logic [3:0]  f_alu_func1;
    logic [1:0]  f_alu_func2;

    int total = 0;
    int bad   = 0;
    int nres;

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f1);
        case (f1)
            4'b0000: alu_f = a + b;
            4'b1000: alu_f = a - b;
            4'b0100: alu_f = a ^ b;
            4'b0010: alu_f = {31'b0, $signed(a) < $signed(b)};
            default: alu_f = a;
        endcase
    endfunction

    assign alu_out_i = alu_f(alu_src1_o, alu_src2_o, alu_func1_o);
    assign f_alu_out = alu_f(f_alu_src1, f_alu_src2, f_alu_func1);

    alu_arbiter #(.DATA_W(32), .PRIO_FIXED(1'b0)) u_dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .r0_valid_i(r0_valid_i), .r0_ready_o(r0_ready_o), .r0_src1_i(r0_src1_i), .r0_src2_i(r0_src2_i),
        .r0_func1_i(r0_func1_i), .r0_func2_i(r0_func2_i), .r0_rvalid_o(r0_rvalid_o),
        .r0_result_o(r0_result_o), .r0_rready_i(r0_rready_i),
        .r1_valid_i(r1_valid_i), .r1_ready_o(r1_ready_o), .r1_src1_i(r1_src1_i), .r1_src2_i(r1_src2_i),
        .r1_func1_i(r1_func1_i), .r1_func2_i(r1_func2_i), .r1_rvalid_o(r1_rvalid_o),
        .r1_result_o(r1_result_o), .r1_rready_i(r1_rready_i),
        .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .alu_func1_o(alu_func1_o),
        .alu_func2_o(alu_func2_o), .alu_out_i(alu_out_i)
    );

    alu_arbiter #(.DATA_W(32), .PRIO_FIXED(1'b1)) u_fix (
        .clk_i(clk_i), .reset_i(reset_i),
        .r0_valid_i(r0_valid_i), .r0_ready_o(f_r0_ready), .r0_src1_i(r0_src1_i), .r0_src2_i(r0_src2_i),
        .r0_func1_i(r0_func1_i), .r0_func2_i(r0_func2_i), .r0_rvalid_o(f_r0_rvalid),
        .r0_result_o(f_r0_result), .r0_rready_i(r0_rready_i),
        .r1_valid_i(r1_valid_i), .r1_ready_o(f_r1_ready), .r1_src1_i(r1_src1_i), .r1_src2_i(r1_src2_i),
        .r1_func1_i(r1_func1_i), .r1_func2_i(r1_func2_i), .r1_rvalid_o(f_r1_rvalid),
        .r1_result_o(f_r1_result), .r1_rready_i(r1_rready_i),
        .alu_src1_o(f_alu_src1), .alu_src2_o(f_alu_src2), .alu_func1_o(f_alu_func1),
        .alu_func2_o(f_alu_func2), .alu_out_i(f_alu_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_reset();
        reset_i = 1'b1;
        #3;
        reset_i = 1'b0;
    endtask

    task automatic set_r0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
        r0_valid_i = v; r0_src1_i = a; r0_src2_i = b; r0_func1_i = f; r0_func2_i = 2'b00;
    endtask

    task automatic set_r1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
        r1_valid_i = v; r1_src1_i = a; r1_src2_i = b; r1_func1_i = f; r1_func2_i = 2'b01;
    endtask

    initial begin
        reset_i = 1'b1;
        set_r0(1'b0, 0, 0, 4'b0000);
        set_r1(1'b0, 0, 0, 4'b0000);
        r0_rready_i = 1'b0;
        r1_rready_i = 1'b0;
        #2;
        // Reset state
        chk("rst_r0_ready", {31'b0, r0_ready_o}, 0);
        chk("rst_r1_ready", {31'b0, r1_ready_o}, 0);
        chk("rst_r0_rvalid", {31'b0, r0_rvalid_o}, 0);
        chk("rst_r1_rvalid", {31'b0, r1_rvalid_o}, 0);
        chk("rst_func1", {28'b0, alu_func1_o}, 32'hF);
        chk("rst_func2", {30'b0, alu_func2_o}, 0);
        chk("rst_src1", alu_src1_o, 0);
        chk("rst_fix_func", {26'b0, f_alu_func1, f_alu_func2}, 32'h3C);
        chk("rst_fix_rvalid", {30'b0, f_r0_rvalid, f_r1_rvalid}, 0);
        step();
        reset_i = 1'b0;
        step();

        // Single op: 5 + 7
        set_r0(1'b1, 5, 7, 4'b0000);
        #1 chk("single_ready", {31'b0, r0_ready_o}, 1);
        step();
        set_r0(1'b0, 0, 0, 4'b0000);
        chk("single_alu_src1", alu_src1_o, 5);
        chk("single_alu_src2", alu_src2_o, 7);
        chk("single_alu_func1", {28'b0, alu_func1_o}, 0);
        chk("single_rvalid_early", {31'b0, r0_rvalid_o}, 0);
        step();
        chk("single_rvalid", {31'b0, r0_rvalid_o}, 1);
        chk("single_result", r0_result_o, 12);
        chk("single_alu_idle", {28'b0, alu_func1_o}, 32'hF);
        r0_rready_i = 1'b1;
        step();
        chk("single_drained", {31'b0, r0_rvalid_o}, 0);

        // Simultaneous: r0 wins first after reset
        pulse_reset();
        step();
        r1_rready_i = 1'b1;
        set_r0(1'b1, 10, 3, 4'b1000);
        set_r1(1'b1, 32'hF0, 32'hFF, 4'b0100);
        #1;
        chk("sim_r0_ready", {31'b0, r0_ready_o}, 1);
        chk("sim_r1_ready0", {31'b0, r1_ready_o}, 0);
        step();
        chk("sim_r1_ready1", {31'b0, r1_ready_o}, 1);
        chk("sim_alu_r0", alu_src1_o, 10);
        set_r0(1'b0, 0, 0, 4'b0000);
        step();
        set_r1(1'b0, 0, 0, 4'b0000);
        chk("sim_r0_rvalid", {31'b0, r0_rvalid_o}, 1);
        chk("sim_r0_result", r0_result_o, 7);
        chk("sim_alu_r1", alu_src1_o, 32'hF0);
        step();
        chk("sim_r1_rvalid", {31'b0, r1_rvalid_o}, 1);
        chk("sim_r1_result", r1_result_o, 32'h0F);
        chk("sim_r0_gone", {31'b0, r0_rvalid_o}, 0);
        step();

        // Back-pressure on r0 while r1 streams
        r0_rready_i = 1'b0;
        set_r0(1'b1, 5, 7, 4'b0000);
        #1 chk("bp_first_ready", {31'b0, r0_ready_o}, 1);
        step();
        set_r0(1'b0, 0, 0, 4'b0000);
        step();
        chk("bp_held_rvalid", {31'b0, r0_rvalid_o}, 1);
        set_r0(1'b1, 1, 1, 4'b0000);
        set_r1(1'b1, 100, 1, 4'b0000);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("bp_r0_blocked", {31'b0, r0_ready_o}, 0);
            chk("bp_r0_stable", r0_result_o, 12);
            chk("bp_r1_cadence", {31'b0, r1_ready_o}, (i % 2 == 0) ? 1 : 0);
            if (r1_rvalid_o) chk("bp_r1_result", r1_result_o, 101);
            step();
        end
        r0_rready_i = 1'b1;
        #1;
        chk("bp_release_r0", {31'b0, r0_ready_o}, 1);
        chk("bp_release_r1", {31'b0, r1_ready_o}, 0);
        step();
        set_r0(1'b0, 0, 0, 4'b0000);
        set_r1(1'b0, 0, 0, 4'b0000);
        chk("bp_new_alu", alu_src1_o, 1);
        chk("bp_drained", {31'b0, r0_rvalid_o}, 0);
        step();
        chk("bp_new_result", r0_result_o, 2);
        step();
        step();

        // Streaming: last grant was r0, so r1 leads and grants alternate
        nres = 0;
        set_r0(1'b1, 1, 2, 4'b0000);
        set_r1(1'b1, 32'hF0, 32'hFF, 4'b0100);
        for (int i = 0; i < 23; i++) begin
            if (i == 20) begin
                set_r0(1'b0, 0, 0, 4'b0000);
                set_r1(1'b0, 0, 0, 4'b0000);
            end
            #1;
            if (i < 20) begin
                chk("str_r1_grant", {31'b0, r1_ready_o}, (i % 2 == 0) ? 1 : 0);
                chk("str_r0_grant", {31'b0, r0_ready_o}, (i % 2 == 1) ? 1 : 0);
            end
            if (i >= 1 && i <= 20) chk("str_alu_busy", {31'b0, alu_func1_o == 4'hF}, 0);
            if (r0_rvalid_o) begin
                nres++;
                chk("str_r0_result", r0_result_o, 3);
            end
            if (r1_rvalid_o) begin
                nres++;
                chk("str_r1_result", r1_result_o, 32'h0F);
            end
            step();
        end
        chk("str_result_count", nres, 20);

        // Fixed priority versus round-robin once r0 was last granted
        pulse_reset();
        step();
        set_r0(1'b1, 5, 7, 4'b0000);
        step();
        set_r0(1'b0, 0, 0, 4'b0000);
        step();
        step();
        set_r0(1'b1, 2, 2, 4'b0000);
        set_r1(1'b1, 3, 3, 4'b0000);
        #1;
        chk("rr_r1_wins", {30'b0, r0_ready_o, r1_ready_o}, 32'b01);
        chk("fix_r0_wins", {30'b0, f_r0_ready, f_r1_ready}, 32'b10);
        step();
        chk("fix_r1_when_r0_busy", {30'b0, f_r0_ready, f_r1_ready}, 32'b01);
        step();
        chk("fix_r0_again", {30'b0, f_r0_ready, f_r1_ready}, 32'b10);
        set_r0(1'b0, 0, 0, 4'b0000);
        set_r1(1'b0, 0, 0, 4'b0000);
        step();
        step();
        step();

        // Async reset with an r1 op in flight
        set_r1(1'b1, 32'hFFFF_FFFF, 1, 4'b0010);
        #1 chk("ar_r1_ready", {31'b0, r1_ready_o}, 1);
        step();
        set_r1(1'b0, 0, 0, 4'b0000);
        chk("ar_stage_func", {28'b0, alu_func1_o}, 32'h2);
        #2 reset_i = 1'b1;
        #1;
        chk("ar_func_idle", {28'b0, alu_func1_o}, 32'hF);
        chk("ar_src_idle", alu_src1_o, 0);
        step();
        reset_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ar_no_rvalid", {31'b0, r1_rvalid_o}, 0);
            step();
        end
        set_r0(1'b1, 1, 1, 4'b0000);
        set_r1(1'b1, 1, 1, 4'b0000);
        #1;
        chk("ar_first_grant", {30'b0, r0_ready_o, r1_ready_o}, 32'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single 32-bit integer ALU between two requesters, e.g. requester 0 = main pipeline execute issue and requester 1 = a multi-cycle helper unit (CSR/atomic sequencer).
- Requesters hand over operations with a valid/ready handshake; a round-robin arbiter selects one operation per cycle.
- The selected operation is registered into an issue stage that drives the ALU. The combinational ALU result is captured into a per-requester one-entry result buffer and returned with a second valid/ready handshake.

Parameters:
- DATA_W, 32, operand/result width; must be 32 (ALU width).
- PRIO_FIXED, 0, 0 = round-robin; 1 = requester 0 always wins when both are eligible.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- rN_valid_i  input  1  requester N (N=0,1) presents an operation.
- rN_ready_o  output  1  operation accepted this cycle when high together with rN_valid_i.
- rN_src1_i  input  DATA_W  operand 1.
- rN_src2_i  input  DATA_W  operand 2.
- rN_func1_i  input  4  ALU major opcode, passed through uninterpreted.
- rN_func2_i  input  2  ALU sub-opcode, passed through uninterpreted.
- rN_rvalid_o  output  1  result available for requester N.
- rN_result_o  output  DATA_W  result data.
- rN_rready_i  input  1  requester N consumes the result.
- alu_src1_o  output  DATA_W  to ALU src1.
- alu_src2_o  output  DATA_W  to ALU src2.
- alu_func1_o  output  4  to ALU func1.
- alu_func2_o  output  2  to ALU func2.
- alu_out_i  input  DATA_W  from ALU alu_out; combinational, same cycle.

Behaviour:
- Reset (async, immediate): stage_v=0; stage_id=0; stage operand regs=0; alu_func1_o=4'b1111, alu_func2_o=2'b00 (pass, idle); both rbuf_v=0; both result regs=0; last_grant=1, so requester 0 wins first; all rN_ready_o=0 and rN_rvalid_o=0.
- Outstanding limit: at most one op per requester, either in the stage or in its result buffer.
  - busy_N = (stage_v & stage_id==N) | (rN_rvalid_o & ~rN_rready_i).
  - elig_N = rN_valid_i & ~busy_N.
- Arbitration (combinational, every cycle):
  - Only one eligible requester: it is granted.
  - Both eligible, PRIO_FIXED=0: grant the one != last_grant. PRIO_FIXED=1: grant 0.
  - rN_ready_o = grant_N. ready may depend combinationally on valid; requesters must not make valid depend on ready.
  - last_grant updates only on an accepted handshake.
- Accept at edge k: stage_v=1, stage_id=N, stage regs load src1/src2/func1/func2. With no accept, stage_v=0 and stage regs return to idle encoding (srcs 0, func1 4'b1111, func2 00).
- Stage drives alu_*_o directly from its registers (no combinational path from request ports to the ALU).
- Edge k+1: alu_out_i is written into result buffer stage_id, setting rbuf_v. Result is visible one edge after acceptance.
- Throughput: one op per cycle aggregate; a single requester with rready tied high achieves one op per 2 cycles.
- Result buffer: rN_rvalid_o holds and rN_result_o stays stable until rN_rready_i.
  - Load and drain in the same cycle is impossible by the busy rule.
  - Drain in the same cycle as accept of a new op from N is allowed.
- rN_rready_i with rvalid low is ignored.
- No op is dropped or duplicated. Results return in per-requester order (trivially, since there is one outstanding each).
- Reset mid-operation: in-flight stage op and unconsumed results are discarded; no rvalid after deassertion until a new accept.

Test Plan:
- Single op: after reset, r0 valid, add 5+7 (func1 0000) -> r0_ready_o=1 at edge 0; alu_src1_o=5 in cycle 1; r0_rvalid_o=1, r0_result_o=12 after edge 1; r0_rready_i=1 clears it.
- Simultaneous requests: r0 sub 10-3, r1 xor 0xF0^0xFF both valid from reset -> r0 granted first (7); r1 next cycle (0x0F); results one cycle apart.
- Back-pressure: r0_rready_i=0 holding result 12 -> r0_ready_o stays 0 for new r0 op and r0_result_o stable; r1 ops keep completing each 2 cycles; raising rready lets r0 be accepted the same cycle.
- Streaming: both valid continuously with rready=1 for 20 cycles -> grants strictly alternate 0,1,0,1; 20 results total; ALU busy every cycle after the first.
- PRIO_FIXED=1: both eligible -> r0 always granted; r1 only granted in cycles where r0 is busy.
- Async reset asserted mid-cycle after accept of r1 slt(-1,1) -> rvalid never rises; ALU outputs go to idle immediately; first post-reset grant goes to r0.
